// File: rtl/ld_sig_tx.sv
// ld_sig_tx: bit-serial frame transmitter for the LightDance signature link.
// Takes NBYTES payload bytes over valid/ready, shifts each byte out LSB
// first while folding every payload bit into an 8-bit signature register,
// then appends that signature as an 8-bit tail so the receiver can compare
// it against its own signature. All outputs come straight from flops.
module ld_sig_tx #(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       start,
    input  logic [7:0] seed,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       sout,
    output logic       sout_valid,
    output logic       sout_last,
    output logic       busy,
    output logic [7:0] sig
);

    // Byte counter only needs to reach NBYTES-1; keep at least one bit.
    localparam int             BCW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        TAIL  = 2'd3
    } state_t;

    // One step of the signature register shared with the receiver. Bit 0
    // is the feedback tap; the new payload bit enters at the top.
    function automatic logic [7:0] sig_step(input logic [7:0] s, input logic d);
        logic [7:0] n;
        n[7] = d ^ s[0];
        n[6] = s[7];
        n[5] = s[6] ^ s[0];
        n[4] = s[5] ^ s[0];
        n[3] = s[4];
        n[2] = s[3];
        n[1] = s[2] ^ s[0];
        n[0] = s[1] ^ s[0];
        return n;
    endfunction

    state_t         state_r;
    logic [7:0]     sig_r;
    logic [7:0]     shift_r;
    logic [2:0]     bit_cnt_r;
    logic [BCW-1:0] byte_cnt_r;

    logic           in_ready_r;
    logic           sout_r;
    logic           sout_valid_r;
    logic           sout_last_r;
    logic           busy_r;

    logic [7:0]     sig_upd_s;

    // Signature after absorbing the payload bit currently on the line.
    assign sig_upd_s = sig_step(sig_r, shift_r[0]);

    // Frame sequencer: state, datapath and the registered outputs are all
    // advanced together so each output flop already holds the value that
    // belongs to the state being entered.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_r      <= IDLE;
            sig_r        <= 8'h00;
            shift_r      <= 8'h00;
            bit_cnt_r    <= 3'd0;
            byte_cnt_r   <= '0;
            in_ready_r   <= 1'b0;
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            sout_last_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // in_valid is deliberately not looked at here.
                    if (start) begin
                        sig_r        <= seed;
                        byte_cnt_r   <= '0;
                        state_r      <= WAIT;
                        in_ready_r   <= 1'b1;
                        busy_r       <= 1'b1;
                        sout_r       <= 1'b0;
                        sout_valid_r <= 1'b0;
                        sout_last_r  <= 1'b0;
                    end else begin
                        in_ready_r   <= 1'b0;
                        sout_r       <= 1'b0;
                        sout_valid_r <= 1'b0;
                        sout_last_r  <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                end

                WAIT: begin
                    // start is ignored; only a payload byte moves us on.
                    if (in_valid) begin
                        shift_r      <= in_data;
                        bit_cnt_r    <= 3'd0;
                        state_r      <= SHIFT;
                        in_ready_r   <= 1'b0;
                        sout_r       <= in_data[0];
                        sout_valid_r <= 1'b1;
                    end else begin
                        in_ready_r   <= 1'b1;
                        sout_valid_r <= 1'b0;
                    end
                end

                SHIFT: begin
                    sig_r     <= sig_upd_s;
                    shift_r   <= {1'b0, shift_r[7:1]};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        if (byte_cnt_r == LAST_BYTE) begin
                            // Tail starts with bit 0 of the final signature.
                            state_r      <= TAIL;
                            bit_cnt_r    <= 3'd0;
                            sout_r       <= sig_upd_s[0];
                            sout_valid_r <= 1'b1;
                        end else begin
                            // Back to WAIT: this is the one-cycle bubble.
                            byte_cnt_r   <= byte_cnt_r + BCW'(1);
                            state_r      <= WAIT;
                            in_ready_r   <= 1'b1;
                            sout_r       <= 1'b0;
                            sout_valid_r <= 1'b0;
                        end
                    end else begin
                        sout_r       <= shift_r[1];
                        sout_valid_r <= 1'b1;
                    end
                end

                TAIL: begin
                    // Plain shift-out, no feedback: sig drains to zero.
                    sig_r     <= {1'b0, sig_r[7:1]};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_r      <= IDLE;
                        sout_r       <= 1'b0;
                        sout_valid_r <= 1'b0;
                        sout_last_r  <= 1'b0;
                        busy_r       <= 1'b0;
                    end else begin
                        sout_r       <= sig_r[1];
                        sout_valid_r <= 1'b1;
                        sout_last_r  <= (bit_cnt_r == 3'd6);
                    end
                end

                default: begin
                    state_r      <= IDLE;
                    in_ready_r   <= 1'b0;
                    sout_r       <= 1'b0;
                    sout_valid_r <= 1'b0;
                    sout_last_r  <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign sout       = sout_r;
    assign sout_valid = sout_valid_r;
    assign sout_last  = sout_last_r;
    assign busy       = busy_r;
    assign sig        = sig_r;

endmodule

// File: tb/tb_ld_sig_tx.sv
// Bench for ld_sig_tx: one NBYTES=1 and one NBYTES=4 instance, selected by
// 'sel'. Frame vectors come from a table; expected serial bits are pushed
// into a scoreboard queue when a frame is launched and popped by a monitor.
module tb_ld_sig_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst, start, in_valid, sel;
    logic [7:0] seed, in_data;

    logic ir1, so1, sv1, sl1, bz1;
    logic ir4, so4, sv4, sl4, bz4;
    logic [7:0] sg1, sg4;

    ld_sig_tx #(.NBYTES(1)) u_dut1 (
        .clk(clk), .arst(arst), .start(start & ~sel), .seed(seed),
        .in_valid(in_valid & ~sel), .in_data(in_data), .in_ready(ir1),
        .sout(so1), .sout_valid(sv1), .sout_last(sl1), .busy(bz1), .sig(sg1)
    );

    ld_sig_tx #(.NBYTES(4)) u_dut4 (
        .clk(clk), .arst(arst), .start(start & sel), .seed(seed),
        .in_valid(in_valid & sel), .in_data(in_data), .in_ready(ir4),
        .sout(so4), .sout_valid(sv4), .sout_last(sl4), .busy(bz4), .sig(sg4)
    );

    logic       c_in_ready, c_sout, c_sout_valid, c_sout_last, c_busy;
    logic [7:0] c_sig;
    assign c_in_ready   = sel ? ir4 : ir1;
    assign c_sout       = sel ? so4 : so1;
    assign c_sout_valid = sel ? sv4 : sv1;
    assign c_sout_last  = sel ? sl4 : sl1;
    assign c_busy       = sel ? bz4 : bz1;
    assign c_sig        = sel ? sg4 : sg1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference signature step: shift right, fold the feedback mask in when
    // bit 0 was set, inject the data bit at the top.
    function automatic logic [7:0] m_upd(input logic [7:0] s, input logic d);
        return (s >> 1) ^ (s[0] ? 8'hB3 : 8'h00) ^ (d ? 8'h80 : 8'h00);
    endfunction

    function automatic logic [7:0] frame_sig(input logic [7:0] sd, input logic [31:0] bytes, input int nb);
        logic [7:0] m;
        m = sd;
        for (int i = 0; i < nb * 8; i++) m = m_upd(m, bytes[i]);
        return m;
    endfunction

    typedef struct packed {
        logic b;
        logic last;
    } exp_bit_t;

    exp_bit_t   sbq[$];
    exp_bit_t   mon_eb;
    logic [7:0] exp_tr[0:135];
    logic [7:0] sig_tr[0:135];
    logic       mon_en = 1'b0;
    int         v_cnt, rdy_cnt, busy_cnt, last_cnt;

    // Monitor: sample outputs on the falling edge, pop/compare serial bits.
    always @(negedge clk) begin
        if (mon_en) begin
            if (c_busy)      busy_cnt++;
            if (c_in_ready)  rdy_cnt++;
            if (c_sout_last) last_cnt++;
            if (c_sout_valid) begin
                if (v_cnt < 136) sig_tr[v_cnt] = c_sig;
                v_cnt++;
                if (sbq.size() == 0) begin
                    chk("extra_bit", {31'd0, c_sout_valid}, 32'd0);
                end else begin
                    mon_eb = sbq.pop_front();
                    chk("sout", {31'd0, c_sout}, {31'd0, mon_eb.b});
                    chk("sout_last", {31'd0, c_sout_last}, {31'd0, mon_eb.last});
                end
            end
        end
    end

    // Launch one frame, build its expectations, and check it end to end.
    task automatic run_frame(input logic s, input logic [7:0] sd, input logic [31:0] bytes,
                             input logic hold, input int stall, input logic [7:0] exp_sig);
        int         nb;
        int         t;
        logic [7:0] m;
        exp_bit_t   e;
        nb = s ? 4 : 1;
        sel = s;
        sbq.delete();
        m = sd;
        for (int i = 0; i < nb * 8; i++) begin
            exp_tr[i] = m;
            e.b = bytes[i];
            e.last = 1'b0;
            sbq.push_back(e);
            m = m_upd(m, bytes[i]);
        end
        for (int k = 0; k < 8; k++) begin
            exp_tr[nb * 8 + k] = m >> k;
            e.b = m[k];
            e.last = (k == 7);
            sbq.push_back(e);
        end
        v_cnt = 0; rdy_cnt = 0; busy_cnt = 0; last_cnt = 0;
        mon_en = 1'b1;

        if (stall > 0) begin
            in_valid = 1'b1;
            in_data  = 8'hC3;
            repeat (2) @(negedge clk);
            chk("idle_in_valid_busy", {31'd0, c_busy}, 32'd0);
            chk("idle_in_valid_ready", {31'd0, c_in_ready}, 32'd0);
            chk("idle_in_valid_sig", {24'd0, c_sig}, 32'h00);
            in_valid = 1'b0;
        end

        start    = 1'b1;
        seed     = sd;
        in_valid = hold;
        in_data  = bytes[7:0];
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", {31'd0, c_busy}, 32'd1);
        chk("wait_in_ready", {31'd0, c_in_ready}, 32'd1);
        chk("wait_sig_seed", {24'd0, c_sig}, {24'd0, sd});

        if (stall > 0) begin
            in_valid = 1'b0;
            for (int k = 0; k < stall; k++) begin
                start = (k == 1);
                seed  = ~sd;
                @(negedge clk);
                chk("stall_sout_valid", {31'd0, c_sout_valid}, 32'd0);
                chk("stall_sig_hold", {24'd0, c_sig}, {24'd0, sd});
                chk("stall_in_ready", {31'd0, c_in_ready}, 32'd1);
            end
            start = 1'b0;
        end

        for (int i = 0; i < nb; i++) begin
            t = 0;
            in_data  = bytes[8 * i +: 8];
            in_valid = hold;
            while (!c_in_ready && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (!c_in_ready) chk("in_ready_timeout", {31'd0, c_in_ready}, 32'd1);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = hold;
        end
        in_valid = 1'b0;

        if (stall > 0) begin
            start = 1'b1;
            seed  = ~sd;
            @(negedge clk);
            start = 1'b0;
            chk("mid_start_busy", {31'd0, c_busy}, 32'd1);
        end

        t = 0;
        while (c_busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (c_busy) chk("frame_end_timeout", {31'd0, c_busy}, 32'd0);

        chk("sb_drained", sbq.size(), 32'd0);
        chk("valid_bits", v_cnt, nb * 8 + 8);
        chk("ready_cycles", rdy_cnt, nb + stall);
        chk("busy_cycles", busy_cnt, 9 * nb + 8 + stall);
        chk("last_pulses", last_cnt, 32'd1);
        chk("sig_before_tail", {24'd0, sig_tr[nb * 8]}, {24'd0, exp_sig});
        for (int i = 0; i < nb * 8 + 8; i++) begin
            if (i < v_cnt) chk("sig_trace", {24'd0, sig_tr[i]}, {24'd0, exp_tr[i]});
        end
        chk("end_sig_zero", {24'd0, c_sig}, 32'h00);
        chk("end_outputs", {27'd0, c_in_ready, c_sout, c_sout_valid, c_sout_last, c_busy}, 32'd0);
    endtask

    typedef struct {
        logic        sel;
        logic [7:0]  seed;
        logic [31:0] bytes;
        logic        hold;
        int          stall;
        logic [7:0]  exp_sig;
        int          mid_idx;
        logic [7:0]  mid_sig;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 8'h00, 32'h0000_0001, 1'b0, 0, 8'h01, 1, 8'h80};
        vecs[1] = '{1'b0, 8'h00, 32'h0000_0003, 1'b0, 0, 8'h03, 2, 8'hC0};
        vecs[2] = '{1'b0, 8'h01, 32'h0000_0000, 1'b1, 0, 8'h32, 2, 8'hEA};
        vecs[3] = '{1'b1, 8'h00, 32'h00FF_5AA5, 1'b1, 0,
                    frame_sig(8'h00, 32'h00FF_5AA5, 4), 0, 8'h00};
        vecs[4] = '{1'b1, 8'h5C, 32'h7856_3412, 1'b0, 5,
                    frame_sig(8'h5C, 32'h7856_3412, 4), 0, 8'h5C};
        vecs[5] = '{1'b0, 8'hFF, 32'h0000_0080, 1'b0, 2,
                    frame_sig(8'hFF, 32'h0000_0080, 1), 1, 8'hB3 ^ 8'h7F};

        arst = 1'b0; start = 1'b0; in_valid = 1'b0; seed = 8'h00; in_data = 8'h00; sel = 1'b0;
        #1;
        chk("rst_outputs_n1", {27'd0, c_in_ready, c_sout, c_sout_valid, c_sout_last, c_busy}, 32'd0);
        chk("rst_sig_n1", {24'd0, c_sig}, 32'h00);
        sel = 1'b1;
        #1;
        chk("rst_outputs_n4", {27'd0, c_in_ready, c_sout, c_sout_valid, c_sout_last, c_busy}, 32'd0);
        chk("rst_sig_n4", {24'd0, c_sig}, 32'h00);
        sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].sel, vecs[v].seed, vecs[v].bytes, vecs[v].hold,
                      vecs[v].stall, vecs[v].exp_sig);
            chk("sig_mid", {24'd0, sig_tr[vecs[v].mid_idx]}, {24'd0, vecs[v].mid_sig});
        end

        // Asynchronous reset in the middle of byte 2 of a 4-byte frame.
        mon_en = 1'b0;
        sbq.delete();
        sel = 1'b1;
        @(negedge clk);
        start = 1'b1; seed = 8'h77; in_valid = 1'b1; in_data = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in_data = 8'hBB;
        repeat (11) @(negedge clk);
        chk("pre_reset_valid", {31'd0, c_sout_valid}, 32'd1);
        chk("pre_reset_busy", {31'd0, c_busy}, 32'd1);
        in_valid = 1'b0;
        #2;
        arst = 1'b0;
        #1;
        chk("async_rst_outputs", {27'd0, c_in_ready, c_sout, c_sout_valid, c_sout_last, c_busy}, 32'd0);
        chk("async_rst_sig", {24'd0, c_sig}, 32'h00);
        @(negedge clk);
        @(negedge clk);
        chk("rst_held_busy", {31'd0, c_busy}, 32'd0);
        arst = 1'b1;
        @(negedge clk);
        run_frame(1'b1, 8'h00, 32'h1122_3344, 1'b1, 0, frame_sig(8'h00, 32'h1122_3344, 4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
